ps2_device_tx: RTL and testbench

- Device-side PS/2 transmitter. It is the opposite end of the link that the 8042 keyboard/mouse controller receives on.
- Takes scancode or mouse bytes from the MiSTer HPS-input adapter through a valid/ready push port and buffers them in a small FIFO.
- Serialises each byte as an 11-bit PS/2 frame, generating the PS/2 clock itself.
- Drives open-collector-style `_O` outputs feeding the 8042's `PS2_CLK*_I` / `PS2_DATA*_I` lines. Honours host clock-inhibit by aborting and retrying the frame.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_tx_fifo.sv | 63 ++++++
 rtl/ps2_device_tx.sv | 194 +++++++++++++++++++
 tb/tb_ps2_device_tx.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the device-side PS/2 transmitter: FSM states,
// frame length and the frame/parity helpers.
package ps2_pkg;

    localparam int PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLDOFF,
        ST_BIT_HI,
        ST_BIT_LO
    } ps2_state_e;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
    function automatic logic oddParity(input logic [7:0] data);
        return ~(^data);
    endfunction

    // Frame image with bit 0 sent first: start, d0..d7, parity, stop.
    function automatic logic [PS2_FRAME_BITS-1:0] buildFrame(input logic [7:0] data);
        return {1'b1, oddParity(data), data, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Small synchronous FIFO buffering bytes between the push port and the
// PS/2 serialiser. DEPTH must be a power of two so the pointers wrap freely.
module ps2_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      level_q;
    logic             doPush;
    logic             doPop;

    assign full_o  = (level_q == FULL_LEVEL);
    assign empty_o = (level_q == '0);
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign head_o  = mem_q[rdPtr_q];
    assign level_o = level_q;

    // Storage array; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves the level alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: buffers pushed bytes and sends each as an
// 11-bit frame while generating the PS/2 clock, backing off and retrying
// whenever the host inhibits the clock during a high phase.
module ps2_device_tx #(
    parameter int CLK_HALF   = 286,
    parameter int HOLDOFF    = 358,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    input  logic                        ps2_clk_i,
    input  logic                        ps2_data_i,
    output logic                        ps2_clk_o,
    output logic                        ps2_data_o,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        aborted
);

    import ps2_pkg::*;

    localparam int CNT_MAX = (CLK_HALF > HOLDOFF) ? CLK_HALF : HOLDOFF;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_HALF - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);
    localparam logic [3:0]       STOP_IDX  = 4'(PS2_FRAME_BITS - 1);

    ps2_state_e                state_q;
    ps2_state_e                state_d;
    logic [CNT_W-1:0]          cnt_q;
    logic [CNT_W-1:0]          cnt_d;
    logic [3:0]                bitIdx_q;
    logic [3:0]                bitIdx_d;
    logic [PS2_FRAME_BITS-1:0] shift_q;
    logic [PS2_FRAME_BITS-1:0] shift_d;
    logic                      aborted_q;
    logic [1:0]                clkSync_q;
    logic [1:0]                dataSync_q;

    logic       clkSynced;
    logic       dataSynced;
    logic       txAccept;
    logic       fifoPop;
    logic       fifoFull;
    logic       fifoEmpty;
    logic [7:0] fifoHead;
    logic       abortEvent;
    logic       stillNonEmpty;

    assign clkSynced  = clkSync_q[1];
    assign dataSynced = dataSync_q[1];
    assign tx_ready   = !fifoFull;
    assign txAccept   = tx_valid && tx_ready;
    assign aborted    = aborted_q;
    assign busy       = (state_q != ST_IDLE) || (fifo_level != '0);

    // After popping the last-but-one entry the queue stays occupied; a same-cycle push also counts.
    assign stillNonEmpty = (fifo_level > LVL_W'(1)) || txAccept;

    ps2_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (txAccept),
        .data_i  (tx_data),
        .pop_i   (fifoPop),
        .head_o  (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .level_o (fifo_level)
    );

    // Two-flop synchronisers for the sensed bus lines; they idle high like a released bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clkSync_q  <= 2'b11;
            dataSync_q <= 2'b11;
        end else begin
            clkSync_q  <= {clkSync_q[0], ps2_clk_i};
            dataSync_q <= {dataSync_q[0], ps2_data_i};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame datapath registers: phase counter, bit index, frame shifter and abort pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            bitIdx_q  <= '0;
            shift_q   <= '1;
            aborted_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bitIdx_q  <= bitIdx_d;
            shift_q   <= shift_d;
            aborted_q <= abortEvent;
        end
    end

    // Next-state logic: idle-bus holdoff, then alternating clock phases per frame bit.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bitIdx_d   = bitIdx_q;
        shift_d    = shift_q;
        fifoPop    = 1'b0;
        abortEvent = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifoEmpty) begin
                    state_d = ST_HOLDOFF;
                    cnt_d   = '0;
                end
            end
            ST_HOLDOFF: begin
                if (!(clkSynced && dataSynced)) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d  = ST_BIT_HI;
                    cnt_d    = '0;
                    bitIdx_d = '0;
                    shift_d  = buildFrame(fifoHead);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BIT_HI: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!clkSynced) begin
                        abortEvent = 1'b1;
                        state_d    = ST_HOLDOFF;
                    end else begin
                        state_d = ST_BIT_LO;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BIT_LO: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (bitIdx_q == STOP_IDX) begin
                        fifoPop = 1'b1;
                        state_d = stillNonEmpty ? ST_HOLDOFF : ST_IDLE;
                    end else begin
                        bitIdx_d = bitIdx_q + 4'd1;
                        shift_d  = {1'b1, shift_q[PS2_FRAME_BITS-1:1]};
                        state_d  = ST_BIT_HI;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line drivers: clock pulled low only in the low phase, data only while a frame is on the wire.
    always_comb begin
        ps2_clk_o  = 1'b1;
        ps2_data_o = 1'b1;
        unique case (state_q)
            ST_BIT_HI: begin
                ps2_data_o = shift_q[0];
            end
            ST_BIT_LO: begin
                ps2_clk_o  = 1'b0;
                ps2_data_o = shift_q[0];
            end
            default: begin
                ps2_clk_o  = 1'b1;
                ps2_data_o = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Self-checking bench for ps2_device_tx: a host-side receiver model decodes
// frames from the falling edges of the device clock and a byte queue predicts
// FIFO occupancy, while directed scenarios exercise inhibit, reset and RTS.
module tb_ps2_device_tx;

    localparam int CLK_HALF   = 6;
    localparam int HOLDOFF    = 10;
    localparam int FIFO_DEPTH = 8;
    localparam int LW         = $clog2(FIFO_DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    tx_data = 8'h00;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          ps2_clk_o;
    logic          ps2_data_o;
    logic          busy;
    logic          aborted;
    logic [LW-1:0] fifo_level;
    logic          hostClk = 1'b1;
    logic          hostData = 1'b1;
    logic          busClk;
    logic          busData;

    assign busClk  = ps2_clk_o & hostClk;
    assign busData = ps2_data_o & hostData;

    int checks = 0;
    int passes = 0;

    // Model state shared between the compare process and the scenarios.
    logic [7:0]  expQ[$];
    int          modelLevel = 0;
    logic        prevValid = 1'b0;
    logic [7:0]  prevData = 8'h00;
    logic        prevClkO = 1'b1;
    logic        prevDataO = 1'b1;
    logic        prevAborted = 1'b0;
    int          rxCount = 0;
    logic [10:0] rxBits = '0;
    logic        rxComplete = 1'b0;
    logic [10:0] lastFrame = '0;
    int          framesRx = 0;
    int          fallsTotal = 0;
    int          abortsSeen = 0;
    int          sinceStart = 0;
    int          sinceFall = 0;
    int          idleRun = 0;
    int          sinceHostLow = 1000;

    ps2_device_tx #(
        .CLK_HALF   (CLK_HALF),
        .HOLDOFF    (HOLDOFF),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_i  (busClk),
        .ps2_data_i (busData),
        .ps2_clk_o  (ps2_clk_o),
        .ps2_data_o (ps2_data_o),
        .busy       (busy),
        .fifo_level (fifo_level),
        .aborted    (aborted)
    );

    // Free-running 10 ns system clock.
    always #5 clk = ~clk;

    // Hard stop in case a scenario wedges despite its own cycle budgets.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [10:0] expFrame(input logic [7:0] d);
        return {1'b1, ~(^d), d, 1'b0};
    endfunction

    // Drives the push port for the next rising edge.
    task automatic applyStimulus(input logic valid, input logic [7:0] data);
        @(posedge clk);
        #1;
        tx_valid = valid;
        tx_data  = data;
    endtask

    task automatic waitFrames(input int target, input int budget, input string name);
        int n = 0;
        while (framesRx < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (framesRx < target) begin
            checkOutput({name, "_timeout"}, framesRx, target);
        end
    endtask

    task automatic waitPhase(input int count, input logic clkLevel, input int budget, input string name);
        int n = 0;
        while (!(rxCount == count && ps2_clk_o == clkLevel) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (!(rxCount == count && ps2_clk_o == clkLevel)) begin
            checkOutput({name, "_timeout"}, rxCount, count);
        end
    endtask

    // Every-cycle reference: predict occupancy from accepted pushes and completed frames,
    // decode frames as the host would on falling clock edges, and police the bus timing.
    always @(negedge clk) begin
        logic pushNow;
        logic popNow;
        logic [7:0] expByte;
        if (!reset_n) begin
            expQ.delete();
            modelLevel = 0;
            rxCount    = 0;
            rxComplete = 1'b0;
        end else begin
            pushNow = prevValid && (modelLevel < FIFO_DEPTH);
            popNow  = rxComplete && !prevClkO && ps2_clk_o;
            if (pushNow) expQ.push_back(prevData);
            if (popNow) rxComplete = 1'b0;
            modelLevel = modelLevel + int'(pushNow) - int'(popNow);
            checkOutput("fifo_level", 32'(fifo_level), modelLevel);
            checkOutput("tx_ready", tx_ready, modelLevel < FIFO_DEPTH);
            checkOutput("busy", busy, modelLevel != 0);

            if (aborted) begin
                checkOutput("abort_release", {ps2_clk_o, ps2_data_o}, 2'b11);
                checkOutput("abort_single", prevAborted, 0);
                checkOutput("abort_cause", sinceHostLow <= CLK_HALF + 4, 1);
                rxCount = 0;
                abortsSeen++;
            end

            if (rxCount == 0 && prevDataO && !ps2_data_o && ps2_clk_o) begin
                checkOutput("holdoff_gap", idleRun >= HOLDOFF, 1);
                sinceStart = 0;
            end

            if (prevClkO && !ps2_clk_o) begin
                fallsTotal++;
                if (rxCount == 0) checkOutput("first_fall", sinceStart, CLK_HALF);
                else              checkOutput("bit_period", sinceFall, 2 * CLK_HALF);
                sinceFall = 0;
                rxBits[rxCount] = ps2_data_o;
                rxCount++;
                if (rxCount == 11) begin
                    if (expQ.size() == 0) begin
                        checkOutput("frame_unexpected", rxBits, 0);
                    end else begin
                        expByte = expQ.pop_front();
                        checkOutput("frame", rxBits, expFrame(expByte));
                    end
                    lastFrame  = rxBits;
                    rxComplete = 1'b1;
                    rxCount    = 0;
                    framesRx++;
                end
            end

            if (!prevClkO && ps2_clk_o) begin
                checkOutput("low_phase", sinceFall, CLK_HALF);
            end
        end
        idleRun      = (busClk && busData) ? idleRun + 1 : 0;
        sinceHostLow = hostClk ? sinceHostLow + 1 : 0;
        sinceFall++;
        sinceStart++;
        prevValid   = tx_valid;
        prevData    = tx_data;
        prevClkO    = ps2_clk_o;
        prevDataO   = ps2_data_o;
        prevAborted = aborted;
    end

    // Directed scenarios followed by a randomized burst.
    initial begin
        int f0;
        int a0;
        logic [7:0] b;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_clk_o", ps2_clk_o, 1);
        checkOutput("rst_data_o", ps2_data_o, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_aborted", aborted, 0);
        checkOutput("rst_level", 32'(fifo_level), 0);
        checkOutput("rst_ready", tx_ready, 1);
        reset_n = 1'b1;

        $display("[TB] single byte 0x1C");
        f0 = framesRx;
        applyStimulus(1'b1, 8'h1C);
        applyStimulus(1'b0, 8'h00);
        waitFrames(f0 + 1, 1000, "t1");
        checkOutput("t1_bits", lastFrame, 11'h438);
        repeat (CLK_HALF + 1) @(posedge clk);
        #1;
        checkOutput("t1_idle", busy, 0);

        $display("[TB] back-to-back 0x00, 0xFF");
        f0 = framesRx;
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'hFF);
        applyStimulus(1'b0, 8'h00);
        checkOutput("t2_level2", 32'(fifo_level), 2);
        waitFrames(f0 + 1, 1000, "t2a");
        checkOutput("t2_frame00", lastFrame, 11'h600);
        repeat (CLK_HALF + 1) @(posedge clk);
        #1;
        checkOutput("t2_level1", 32'(fifo_level), 1);
        waitFrames(f0 + 2, 1000, "t2b");
        checkOutput("t2_frameFF", lastFrame, 11'h7FE);
        repeat (CLK_HALF + 1) @(posedge clk);
        #1;
        checkOutput("t2_level0", 32'(fifo_level), 0);

        $display("[TB] host inhibit during bit 4");
        b  = 8'($urandom);
        f0 = framesRx;
        a0 = abortsSeen;
        applyStimulus(1'b1, b);
        applyStimulus(1'b0, 8'h00);
        waitPhase(4, 1'b1, 1000, "t3_phase");
        #1;
        hostClk = 1'b0;
        repeat (3 * CLK_HALF) @(posedge clk);
        #1;
        checkOutput("t3_abort_count", abortsSeen, a0 + 1);
        checkOutput("t3_level_held", 32'(fifo_level), 1);
        checkOutput("t3_no_frame", framesRx, f0);
        hostClk = 1'b1;
        waitFrames(f0 + 1, 1000, "t3");
        checkOutput("t3_resent", lastFrame, expFrame(b));
        checkOutput("t3_abort_once", abortsSeen, a0 + 1);

        $display("[TB] fill FIFO while inhibited");
        repeat (2 * CLK_HALF) @(posedge clk);
        f0 = framesRx;
        hostClk = 1'b0;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 8'($urandom));
        end
        applyStimulus(1'b0, 8'h00);
        checkOutput("t4_full_level", 32'(fifo_level), FIFO_DEPTH);
        checkOutput("t4_full_ready", tx_ready, 0);
        repeat (20) @(posedge clk);
        #1;
        hostClk = 1'b1;
        waitFrames(f0 + 8, 3000, "t4");
        repeat (300) @(posedge clk);
        checkOutput("t4_frames", framesRx, f0 + 8);

        $display("[TB] reset during bit 6");
        b  = 8'($urandom) & 8'hDF;
        f0 = framesRx;
        a0 = fallsTotal;
        applyStimulus(1'b1, b);
        applyStimulus(1'b0, 8'h00);
        waitPhase(7, 1'b0, 1000, "t5_phase");
        #1;
        checkOutput("t5_pre_lines", {ps2_clk_o, ps2_data_o}, 2'b00);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("t5_lines", {ps2_clk_o, ps2_data_o}, 2'b11);
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_level", 32'(fifo_level), 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        a0 = fallsTotal;
        repeat (200) @(posedge clk);
        #1;
        checkOutput("t5_no_frame", fallsTotal, a0);
        checkOutput("t5_idle", busy, 0);

        $display("[TB] host request-to-send blocks start");
        hostData = 1'b0;
        f0 = framesRx;
        a0 = fallsTotal;
        b  = 8'($urandom);
        applyStimulus(1'b1, b);
        applyStimulus(1'b0, 8'h00);
        repeat (4 * HOLDOFF) @(posedge clk);
        #1;
        checkOutput("t6_blocked", fallsTotal, a0);
        checkOutput("t6_lines", {ps2_clk_o, ps2_data_o}, 2'b11);
        checkOutput("t6_level", 32'(fifo_level), 1);
        hostData = 1'b1;
        waitFrames(f0 + 1, 1000, "t6");
        checkOutput("t6_frame", lastFrame, expFrame(b));

        $display("[TB] randomized pushes");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 8'($urandom));
            applyStimulus(1'b0, 8'h00);
            repeat ($urandom_range(0, 200)) @(posedge clk);
        end
        begin
            int n = 0;
            while (modelLevel != 0 && n < 5000) begin
                @(posedge clk);
                n++;
            end
        end
        repeat (5) @(posedge clk);
        #1;
        checkOutput("rand_drained", 32'(fifo_level), 0);
        checkOutput("rand_queue_empty", expQ.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
